// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Saturation is controlled by the SERIAL_SUB_SAT_EN macro in serial_subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width; a one-bit operand still needs a one-bit counter.
    function automatic int cnt_w(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow out.
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/ready/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp a negative result to zero instead of wrapping.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             d_s;
    logic             bout_s;
    logic [WIDTH-1:0] res_shift_s;
    logic             last_bit_s;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (d_s),
        .bout (bout_s)
    );

    // Result register fills from the MSB side; after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_shift_s            = res_q >> 1'b1;
        res_shift_s[WIDTH-1]   = d_s;
        last_bit_s             = (bit_cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM, serial datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= {WIDTH{1'b0}};
            b_sh_q       <= {WIDTH{1'b0}};
            res_q        <= {WIDTH{1'b0}};
            bit_cnt_q    <= {CW{1'b0}};
            borrow_q     <= 1'b0;
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q    <= a;
                        b_sh_q    <= b;
                        res_q     <= {WIDTH{1'b0}};
                        bit_cnt_q <= {CW{1'b0}};
                        borrow_q  <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1'b1;
                    b_sh_q   <= b_sh_q >> 1'b1;
                    res_q    <= res_shift_s;
                    borrow_q <= bout_s;
                    if (last_bit_s) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff_q <= bout_s ? {WIDTH{1'b0}} : res_shift_s;
`else
                        diff_q <= res_shift_s;
`endif
                        borrow_out_q <= bout_s;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        bit_cnt_q    <= {CW{1'b0}};
                        state_q      <= DONE;
                    end else begin
                        bit_cnt_q    <= bit_cnt_q + CW'(1);
                        state_q      <= RUN;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1 (SERIAL_SUB_SAT_EN aware).
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       ready8, busy8, done8, bo8;
    logic       ready1, busy1, done1, bo1;
    logic [7:0] diff8;
    logic [0:0] diff1;

    int tests;
    int fails;
    bit sel1;
    logic [7:0] last_d8, last_d1;
    logic       last_b8, last_b1;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_ready(); return sel1 ? ready1 : ready8; endfunction
    function automatic logic m_busy();  return sel1 ? busy1  : busy8;  endfunction
    function automatic logic m_done();  return sel1 ? done1  : done8;  endfunction
    function automatic logic m_bo();    return sel1 ? bo1    : bo8;    endfunction
    function automatic logic [7:0] m_diff(); return sel1 ? {7'd0, diff1} : diff8; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: w-bit unsigned subtraction by plain integer arithmetic.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input int w,
                         output logic [7:0] d, output logic bo);
        int m, ai, bi, r;
        m  = 1 << w;
        ai = int'(av) % m;
        bi = int'(bv) % m;
        bo = (ai < bi);
        r  = (ai - bi + m) % m;
`ifdef SERIAL_SUB_SAT_EN
        if (bo) r = 0;
`endif
        d = r[7:0];
    endtask

    task automatic drive(input bit w1, input logic s, input logic [7:0] av, input logic [7:0] bv);
        if (w1) begin
            start1 = s; a1 = av[0:0]; b1 = bv[0:0];
        end else begin
            start8 = s; a8 = av; b8 = bv;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One handshake; optionally pulses start with other operands at RUN sample pulse_at.
    task automatic run_op(input bit w1, input logic [7:0] av, input logic [7:0] bv, input int pulse_at);
        int cyc, w;
        logic [7:0] ed, ld;
        logic eb, lb;
        sel1 = w1;
        w = w1 ? 1 : 8;
        model(av, bv, w, ed, eb);
        ld = w1 ? last_d1 : last_d8;
        lb = w1 ? last_b1 : last_b8;
        cyc = 0;
        while (!m_ready() && cyc < 50) begin tick(); cyc++; end
        check("ready_before_op", {31'd0, m_ready()}, 32'd1);
        drive(w1, 1'b1, av, bv);
        tick();
        drive(w1, 1'b0, av, bv);
        cyc = 0;
        while (m_done() !== 1'b1 && cyc < 50) begin
            check("diff_stable_in_run", {24'd0, m_diff()}, {24'd0, ld});
            check("borrow_stable_in_run", {31'd0, m_bo()}, {31'd0, lb});
            if (cyc == pulse_at) drive(w1, 1'b1, ~av, ~bv);
            else drive(w1, 1'b0, av, bv);
            tick();
            cyc++;
        end
        drive(w1, 1'b0, av, bv);
        check("latency", cyc, w);
        check("diff", {24'd0, m_diff()}, {24'd0, ed});
        check("borrow_out", {31'd0, m_bo()}, {31'd0, eb});
        if (w1) begin last_d1 = ed; last_b1 = eb; end
        else begin last_d8 = ed; last_b8 = eb; end
        tick();
        check("done_one_cycle", {31'd0, m_done()}, 32'd0);
        check("ready_after_done", {31'd0, m_ready()}, 32'd1);
        check("diff_held", {24'd0, m_diff()}, {24'd0, ed});
    endtask

    initial begin
        int pulses, last_idx;
        logic [7:0] ed;
        logic eb;
        tests = 0; fails = 0; sel1 = 1'b0;
        last_d8 = 8'h00; last_d1 = 8'h00; last_b8 = 1'b0; last_b1 = 1'b0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_ready", {31'd0, ready8}, 32'd1);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, bo8}, 32'd0);

        run_op(1'b0, 8'h35, 8'h12, -1);
        run_op(1'b0, 8'h12, 8'h35, -1);
        run_op(1'b0, 8'h00, 8'h01, -1);
        run_op(1'b0, 8'hFF, 8'hFF, -1);

        // start during RUN must be ignored
        run_op(1'b0, 8'h35, 8'h12, 3);
        run_op(1'b0, 8'h80, 8'h7F, 7);

        // start held high: a new op every WIDTH+2 cycles
        sel1 = 1'b0;
        drive(1'b0, 1'b1, 8'h50, 8'h61);
        model(8'h50, 8'h61, 8, ed, eb);
        pulses = 0; last_idx = -1;
        for (int i = 0; i < 45; i++) begin
            tick();
            check("ready_busy_exclusive", {31'd0, ready8 & busy8}, 32'd0);
            if (done8) begin
                if (last_idx >= 0) check("held_start_period", i - last_idx, 10);
                check("held_diff", {24'd0, diff8}, {24'd0, ed});
                check("held_borrow", {31'd0, bo8}, {31'd0, eb});
                last_idx = i;
                pulses++;
            end
        end
        check("held_start_pulses", pulses, 4);
        drive(1'b0, 1'b0, 8'h50, 8'h61);
        last_d8 = ed; last_b8 = eb;
        repeat (12) tick();

        // reset at bit 4 of a run, with start also high during reset
        drive(1'b0, 1'b1, 8'h35, 8'h12);
        tick();
        drive(1'b0, 1'b0, 8'h35, 8'h12);
        repeat (4) tick();
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h77, 8'h11);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h77, 8'h11);
        check("abort_ready", {31'd0, ready8}, 32'd1);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_diff", {24'd0, diff8}, 32'd0);
        check("abort_borrow", {31'd0, bo8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle", {31'd0, ready8}, 32'd1);
        last_d8 = 8'h00; last_b8 = 1'b0; last_d1 = 8'h00; last_b1 = 1'b0;
        run_op(1'b0, 8'h35, 8'h12, -1);

        // WIDTH=1 truth table
        run_op(1'b1, 8'h00, 8'h00, -1);
        run_op(1'b1, 8'h00, 8'h01, -1);
        run_op(1'b1, 8'h01, 8'h00, -1);
        run_op(1'b1, 8'h01, 8'h01, -1);

        // random operands against the reference
        for (int n = 0; n < 1000; n++) begin
            run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
